rr_prio_encoder: RTL
====================

Name: rr_prio_encoder

Overview:
- Parametrised, registered N-to-log2(N) encoder that generalises the team's 8-to-3 one-hot encoder.
- Accepts arbitrary (multi-hot) request vectors and resolves them by fixed or round-robin priority.
- Presents the winning index on a valid/ready output stage.
- Sits between request sources (interrupt lines, channel-busy flags) and a single consumer that services one index at a time.

Parameters:
- N, 8, number of request inputs; legal range 2..64.
- W, $clog2(N), index width; derived, not overridden.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- req  input  N  request vector, bit i requests index i; may be multi-hot or zero.
- mode  input  1  0 = fixed priority (lowest index wins), 1 = round-robin.
- out_ready  input  1  consumer accepts the current output this cycle.
- out_valid  output  1  out_idx/out_multi hold a valid result.
- out_idx  output  W  encoded winning index.
- out_multi  output  1  more than one req bit was set when out_idx was sampled.

Behaviour:
- Reset (async assert, sync deassert by the driver): out_valid=0, out_idx=0, out_multi=0, internal pointer ptr=0. Reset mid-transaction drops the held result with no handshake.
- The stage is "open" when out_valid==0, or when out_valid&&out_ready (accept this cycle).
- On a clk edge while open:
  - req != 0: out_idx <= winner, out_multi <= (popcount(req) > 1), out_valid <= 1.
  - req == 0: out_valid <= 0; out_idx and out_multi hold their previous values.
- Latency: one cycle from req to out_valid. Back-to-back throughput is one result per cycle while out_ready=1.
- Hold: while out_valid && !out_ready, out_idx/out_multi/out_valid are stable and req is ignored (not queued). A request that drops before being sampled is lost; sources keep req asserted until serviced.
- Fixed mode: winner = lowest set bit of req.
- Round-robin mode: winner = lowest set index >= ptr; if none, wrap and take the lowest set index < ptr.
- ptr update: only on accept (out_valid && out_ready), ptr <= (out_idx == N-1) ? 0 : out_idx + 1. This applies in both modes, so switching to round-robin continues from the last accepted index.
- mode is sampled at the same edge as req. A change while a result is held affects only the next sample.
- One-hot req: result equals the legacy encoder mapping, with out_multi=0.
- ptr is W bits and never exceeds N-1, including non-power-of-two N.

Optional Feature:
- Macro: RR_PRIO_ENCODER_STRICT_ONEHOT_EN.
- When defined:
  - Adds output port err (1 bit, reset 0).
  - A sampled multi-hot req is rejected: out_valid stays/goes 0, err pulses high for exactly one cycle, and ptr is unchanged.
  - out_multi is tied 0.
  - Mirrors the legacy "invalid pattern" default, with explicit signalling instead of X.
- When undefined: no err port; multi-hot vectors are resolved by priority as above.

Decomposition:
- Package rr_prio_encoder_pkg:
  - MODE_FIXED=1'b0, MODE_RR=1'b1.
  - Function for index width used by testbench and parents.
- Sub-module prio_pick:
  - Purely combinational.
  - Inputs: req[N], ptr[W], mode.
  - Outputs: found, idx[W], multi.
  - Implemented as a masked lowest-set-bit search over the upper region with fallback to the unmasked search.
- Top level: output register stage, handshake, ptr register.

Test Plan (N=8):
- Reset with req=8'hFF held → out_valid=0, out_idx=0, out_multi=0 until rst_n releases; first edge after release → out_idx=0, out_multi=1.
- mode=0, out_ready=1, walk one-hot req 8'h01..8'h80 → out_idx=0..7 one cycle later, out_multi=0 each time.
- mode=1, out_ready=1, req=8'b1010_0100 held 4 cycles → out_idx sequence 2,5,7,2 (wrap).
- mode=1, ptr at 6, req=8'h41, out_ready=0 for 3 cycles then 1 → out_idx=6 stable for all 4 cycles, next result 0.
- req=8'h00 after a valid accept → out_valid=0 next cycle, out_idx keeps last value; async rst_n pulse mid-hold → out_valid=0 immediately.
- STRICT build: req=8'h12 → out_valid=0, err=1 for one cycle; then req=8'h10 → out_idx=4, err=0.

Source files
------------

// File: rtl/rr_prio_encoder_pkg.sv
// Shared constants and helpers for the round-robin priority encoder.
// Used by rr_prio_encoder, prio_pick and their testbenches.
package rr_prio_encoder_pkg;

    localparam logic MODE_FIXED = 1'b0;
    localparam logic MODE_RR    = 1'b1;

    // Index width for an N-input encoder; never narrower than one bit.
    function automatic int idx_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/prio_pick.sv
// Combinational winner selection: lowest set request at or above ptr
// (round-robin) or lowest set request overall (fixed), plus multi-hot flag.
module prio_pick
    import rr_prio_encoder_pkg::*;
#(
    parameter int N = 8,
    parameter int W = idx_width(N)
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] ptr,
    input  logic         mode,
    output logic         found,
    output logic [W-1:0] idx,
    output logic         multi
);

    localparam logic [N-1:0] ONE = N'(1);

    logic [N-1:0] mask;
    logic [N-1:0] upper;
    logic         up_found;
    logic [W-1:0] up_idx;
    logic         lo_found;
    logic [W-1:0] lo_idx;

    always_comb begin
        mask     = '0;
        up_found = 1'b0;
        up_idx   = '0;
        lo_found = 1'b0;
        lo_idx   = '0;
        for (int i = 0; i < N; i++) begin
            mask[i] = (mode == MODE_FIXED) || (i >= int'(ptr));
        end
        upper = req & mask;
        // Descending scan so the last hit left standing is the lowest index.
        for (int i = N - 1; i >= 0; i--) begin
            if (upper[i]) begin
                up_found = 1'b1;
                up_idx   = W'(i);
            end
            if (req[i]) begin
                lo_found = 1'b1;
                lo_idx   = W'(i);
            end
        end
    end

    assign found = lo_found;
    assign idx   = up_found ? up_idx : lo_idx;
    assign multi = |(req & (req - ONE));

endmodule

// File: rtl/rr_prio_encoder.sv
// Registered N-to-log2(N) priority encoder with fixed / round-robin arbitration
// and a valid/ready output stage. Optional macro: RR_PRIO_ENCODER_STRICT_ONEHOT_EN.
module rr_prio_encoder
    import rr_prio_encoder_pkg::*;
#(
    parameter  int N = 8,
    localparam int W = idx_width(N)
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] req,
    input  logic         mode,
    input  logic         out_ready,
    output logic         out_valid,
`ifdef RR_PRIO_ENCODER_STRICT_ONEHOT_EN
    output logic         err,
`endif
    output logic [W-1:0] out_idx,
    output logic         out_multi
);

    logic [W-1:0] ptr_p0;
    logic [W-1:0] next_ptr;
    logic [W-1:0] pick_ptr;
    logic         pick_found;
    logic [W-1:0] pick_idx;
    logic         pick_multi;
    logic         open;
    logic         accept;
    logic         take;

    logic         vld_p1;
    logic [W-1:0] idx_p1;
    logic         multi_p1;

    assign accept   = vld_p1 && out_ready;
    assign open     = !vld_p1 || out_ready;
    assign next_ptr = (idx_p1 == W'(N - 1)) ? '0 : idx_p1 + W'(1);
    // Arbitrate from the post-accept pointer so back-to-back grants rotate.
    assign pick_ptr = accept ? next_ptr : ptr_p0;

    prio_pick #(.N(N), .W(W)) u_pick (
        .req   (req),
        .ptr   (pick_ptr),
        .mode  (mode),
        .found (pick_found),
        .idx   (pick_idx),
        .multi (pick_multi)
    );

`ifdef RR_PRIO_ENCODER_STRICT_ONEHOT_EN
    assign take = pick_found && !pick_multi;
`else
    assign take = pick_found;
`endif

    // Stage p1: output register, pointer and handshake
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p1   <= 1'b0;
            idx_p1   <= '0;
            multi_p1 <= 1'b0;
            ptr_p0   <= '0;
        end else begin
            if (accept) begin
                ptr_p0 <= next_ptr;
            end
            if (open) begin
                vld_p1 <= take;
                if (take) begin
                    idx_p1 <= pick_idx;
`ifdef RR_PRIO_ENCODER_STRICT_ONEHOT_EN
                    multi_p1 <= 1'b0;
`else
                    multi_p1 <= pick_multi;
`endif
                end
            end
        end
    end

`ifdef RR_PRIO_ENCODER_STRICT_ONEHOT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err <= 1'b0;
        end else begin
            err <= open && pick_found && pick_multi;
        end
    end
`endif

    assign out_valid = vld_p1;
    assign out_idx   = idx_p1;
    assign out_multi = multi_p1;

endmodule
